// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the countdown timer slice.
package timer_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Saturate an arbitrary 4-bit value into the legal BCD digit range.
    function automatic bcd_t bcd_clamp(input bcd_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between game control logic and the countdown timer.
interface countdown_timer_if
    import timer_pkg::*;
();
    logic slowclock;
    logic load;
    bcd_t load_tens;
    bcd_t load_ones;
    logic start;
    logic pause;
    bcd_t tens;
    bcd_t ones;
    logic tick;
    logic running;
    logic done;
    logic done_pulse;

    modport master (
        output slowclock, load, load_tens, load_ones, start, pause,
        input  tens, ones, tick, running, done, done_pulse
    );

    modport slave (
        input  slowclock, load, load_tens, load_ones, start, pause,
        output tens, ones, tick, running, done, done_pulse
    );
endinterface

// File: rtl/rising_edge_detect.sv
// Single-flop rising-edge detector; RESET_LEVEL suppresses a spurious edge
// when the input is already high as reset releases.
module rising_edge_detect #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic fastclock,
    input  logic reset,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge fastclock or posedge reset) begin
        if (reset) sig_q <= RESET_LEVEL;
        else       sig_q <= sig;
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer advanced by rising edges of the divided clock.
module countdown_timer
    import timer_pkg::*;
#(
    parameter bcd_t INIT_TENS = 4'd3,
    parameter bcd_t INIT_ONES = 4'd0
) (
    input  logic                fastclock,
    input  logic                reset,
    countdown_timer_if.slave    bus
);

    timer_state_t state_q;
    bcd_t         tens_q;
    bcd_t         ones_q;
    logic         tick_q;
    logic         done_pulse_q;

    logic rise;
    bcd_t dec_tens_c;
    bcd_t dec_ones_c;
    logic dec_zero_c;
    logic count_zero_c;

    // Divider idles high after reset, so the history flop also resets high.
    rising_edge_detect #(.RESET_LEVEL(1'b1)) u_slow_edge (
        .fastclock (fastclock),
        .reset     (reset),
        .sig       (bus.slowclock),
        .pulse     (rise)
    );

    // BCD decrement with borrow; holds at 00 rather than wrapping.
    always_comb begin
        dec_tens_c = tens_q;
        dec_ones_c = ones_q;
        if (ones_q != 4'd0) begin
            dec_ones_c = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
            dec_ones_c = BCD_MAX;
            dec_tens_c = tens_q - 4'd1;
        end
    end

    assign dec_zero_c   = (dec_tens_c == 4'd0) && (dec_ones_c == 4'd0);
    assign count_zero_c = (tens_q == 4'd0) && (ones_q == 4'd0);

    // Priority: load > pause > start > rise.
    always_ff @(posedge fastclock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tens_q       <= INIT_TENS;
            ones_q       <= INIT_ONES;
            tick_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            tick_q       <= rise;
            done_pulse_q <= 1'b0;
            if (bus.load) begin
                state_q <= IDLE;
                tens_q  <= bcd_clamp(bus.load_tens);
                ones_q  <= bcd_clamp(bus.load_ones);
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!bus.pause && bus.start) begin
                            if (count_zero_c) begin
                                state_q      <= DONE;
                                done_pulse_q <= 1'b1;
                            end else begin
                                state_q <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.pause) begin
                            state_q <= PAUSE;
                        end else if (rise) begin
                            tens_q <= dec_tens_c;
                            ones_q <= dec_ones_c;
                            if (dec_zero_c) begin
                                state_q      <= DONE;
                                done_pulse_q <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!bus.pause && bus.start) state_q <= RUN;
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.tens       = tens_q;
    assign bus.ones       = ones_q;
    assign bus.tick       = tick_q;
    assign bus.done_pulse = done_pulse_q;
    assign bus.running    = (state_q == RUN);
    assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

    logic fastclock;
    logic reset;
    int   n_chk;
    int   n_pass;
    int   n_ticks;

    countdown_timer_if bus ();

    countdown_timer #(.INIT_TENS(4'd3), .INIT_ONES(4'd0)) dut (
        .fastclock (fastclock),
        .reset     (reset),
        .bus       (bus)
    );

    initial fastclock = 1'b0;
    always #5 fastclock = ~fastclock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge fastclock);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] count();
        return {bus.tens, bus.ones};
    endfunction

    // Raise slowclock so the next edge sees a rise.
    task automatic rise_edge();
        bus.slowclock = 1'b1;
        step();
    endtask

    // Finish the divider period: remaining high cycles, then low cycles.
    task automatic rest(input int hi, input int lo);
        repeat (hi) step();
        bus.slowclock = 1'b0;
        repeat (lo) step();
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        bus.load      = 1'b1;
        bus.load_tens = t;
        bus.load_ones = o;
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_ticks = 0;
        reset = 1'b1;
        bus.slowclock = 1'b1;
        bus.load = 1'b0; bus.load_tens = 4'd0; bus.load_ones = 4'd0;
        bus.start = 1'b0; bus.pause = 1'b0;
        #12;
        check("rst_count", count(), 8'h30);
        check("rst_running", 8'(bus.running), 8'h0);
        check("rst_done", 8'(bus.done), 8'h0);
        check("rst_tick", 8'(bus.tick), 8'h0);
        step();
        reset = 1'b0;
        repeat (3) begin
            step();
            check("post_rst_no_tick", 8'(bus.tick), 8'h0);
        end
        bus.slowclock = 1'b0;
        repeat (4) step();

        // Borrow and completion from 10.
        do_load(4'd1, 4'd0);
        check("load_10", count(), 8'h10);
        do_start();
        check("start_running", 8'(bus.running), 8'h1);
        for (int i = 1; i <= 10; i++) begin
            rise_edge();
            check("dec_tick", 8'(bus.tick), 8'h1);
            check("dec_count", count(), to_bcd(10 - i));
            if (i == 10) begin
                check("end_done", 8'(bus.done), 8'h1);
                check("end_done_pulse", 8'(bus.done_pulse), 8'h1);
                check("end_running", 8'(bus.running), 8'h0);
            end else begin
                check("mid_done", 8'(bus.done), 8'h0);
            end
            step();
            check("tick_fall", 8'(bus.tick), 8'h0);
            check("done_pulse_low", 8'(bus.done_pulse), 8'h0);
            rest(3, 5);
        end
        check("done_hold", 8'(bus.done), 8'h1);

        // Pause coincident with a rise at 25.
        do_load(4'd2, 4'd5);
        check("load_25_leaves_done", 8'(bus.done), 8'h0);
        do_start();
        bus.pause = 1'b1;
        rise_edge();
        bus.pause = 1'b0;
        check("pause_count", count(), 8'h25);
        check("pause_running", 8'(bus.running), 8'h0);
        check("pause_tick", 8'(bus.tick), 8'h1);
        rest(4, 5);
        repeat (3) begin
            rise_edge();
            check("paused_hold", count(), 8'h25);
            rest(4, 5);
        end
        do_start();
        check("resume_running", 8'(bus.running), 8'h1);
        rise_edge();
        check("resume_dec", count(), 8'h24);
        rest(4, 5);

        // Run down to 17, then reset mid-count.
        for (int i = 23; i >= 18; i--) begin
            rise_edge();
            rest(4, 5);
        end
        rise_edge();
        check("pre_rst_count", count(), 8'h17);
        reset = 1'b1;
        #1;
        check("midrst_count", count(), 8'h30);
        check("midrst_running", 8'(bus.running), 8'h0);
        check("midrst_done", 8'(bus.done), 8'h0);
        check("midrst_tick", 8'(bus.tick), 8'h0);
        step();
        reset = 1'b0;
        repeat (3) begin
            step();
            check("midrst_no_tick", 8'(bus.tick), 8'h0);
            check("midrst_no_pulse", 8'(bus.done_pulse), 8'h0);
        end
        check("midrst_idle_count", count(), 8'h30);
        bus.slowclock = 1'b0;
        repeat (4) step();

        // Clamp and priority.
        bus.start = 1'b1; bus.pause = 1'b1;
        do_load(4'd12, 4'd15);
        bus.start = 1'b0; bus.pause = 1'b0;
        check("clamp_count", count(), 8'h99);
        check("clamp_running", 8'(bus.running), 8'h0);
        check("clamp_done", 8'(bus.done), 8'h0);

        // Zero start.
        do_load(4'd0, 4'd0);
        do_start();
        check("zs_done", 8'(bus.done), 8'h1);
        check("zs_done_pulse", 8'(bus.done_pulse), 8'h1);
        step();
        check("zs_pulse_fall", 8'(bus.done_pulse), 8'h0);
        do_start();
        check("zs_start_stays_done", 8'(bus.done), 8'h1);
        check("zs_no_repulse", 8'(bus.done_pulse), 8'h0);
        do_load(4'd0, 4'd5);
        check("zs_reload_done", 8'(bus.done), 8'h0);
        check("zs_reload_count", count(), 8'h05);
        check("zs_reload_running", 8'(bus.running), 8'h0);

        // Tick stream in IDLE.
        for (int i = 0; i < 20; i++) begin
            rise_edge();
            if (bus.tick === 1'b1) n_ticks++;
            step();
            check("stream_tick_fall", 8'(bus.tick), 8'h0);
            rest(3, 5);
        end
        check("stream_tick_count", 8'(n_ticks), 8'd20);
        check("stream_count", count(), 8'h05);
        check("stream_running", 8'(bus.running), 8'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
